// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/branch unit: opcode values, field
// positions, the decode FSM state type and the default return-stack depth.
package isa_pkg;

  localparam int OP_W                = 6;
  localparam int DEFAULT_STACK_DEPTH = 8;

  // Instruction field positions.
  localparam int OP_MSB  = 31;
  localparam int RS1_MSB = 21;
  localparam int RS2_MSB = 17;
  localparam int REG_W   = 4;
  localparam int IMM14_W = 14;
  localparam int IMM26_W = 26;

  localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h20;
  localparam logic [OP_W-1:0] OP_CALL  = 6'h21;
  localparam logic [OP_W-1:0] OP_RET   = 6'h22;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h23;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h24;
  localparam logic [OP_W-1:0] OP_CALLR = 6'h25;
  localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect-target arithmetic: region jump target and
// PC-relative branch target with sign-extended word offset.
module branch_target_calc
  import isa_pkg::*;
(
  input  logic [31:0]        pc4,
  input  logic [IMM26_W-1:0] imm26,
  input  logic [IMM14_W-1:0] imm14,
  output logic [31:0]        jump_address,
  output logic [31:0]        branch_address
);

  logic [31:0] imm14_sext;

  assign imm14_sext     = {{(32-IMM14_W){imm14[IMM14_W-1]}}, imm14};
  // Jump stays inside the 256 MB region of the following instruction.
  assign jump_address   = {pc4[31:28], imm26, 2'b00};
  assign branch_address = pc4 + (imm14_sext << 2);

endmodule

// File: rtl/decode_branch_unit.sv
// IF/ID register plus control-flow decode: resolves jumps, calls, returns and
// branches, stalls on missing operands or HALT, and guards return-stack depth.
module decode_branch_unit
  import isa_pkg::*;
#(
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int OPW         = OP_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [31:0]                        instructionIn,
  input  logic [31:0]                        PC4In,
  input  logic [31:0]                        rs1Data,
  input  logic [31:0]                        rs2Data,
  input  logic                               operandsReady,
  output logic                               SIG_Jump,
  output logic                               SIG_Call,
  output logic                               SIG_CALL_RS1,
  output logic                               SIG_RET,
  output logic                               SIG_BEQ,
  output logic                               SIG_BNE,
  output logic                               SIG_EQ,
  output logic [31:0]                        jumpAddress,
  output logic [31:0]                        branchAddress,
  output logic [31:0]                        callRs1Address,
  output logic                               stallOut,
  output logic [31:0]                        idInstr,
  output logic [31:0]                        idPC4,
  output logic                               stackErr,
  output logic                               halted,
  output fsm_state_e                         dbg_state,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   dbg_depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  fsm_state_e     state;
  logic [DW-1:0]  depth;
  logic [OPW-1:0] op;

  logic is_j, is_call, is_ret, is_beq, is_bne, is_callr, is_halt;
  logic needs_ops, frozen, wait_ops, active;
  logic depth_full, depth_empty;
  logic call_go, callr_go, ret_go, overflow, underflow;

  assign op       = idInstr[OP_MSB -: OPW];
  assign is_j     = (op == OPW'(OP_J));
  assign is_call  = (op == OPW'(OP_CALL));
  assign is_ret   = (op == OPW'(OP_RET));
  assign is_beq   = (op == OPW'(OP_BEQ));
  assign is_bne   = (op == OPW'(OP_BNE));
  assign is_callr = (op == OPW'(OP_CALLR));
  assign is_halt  = (op == OPW'(OP_HALT));

  // operandsReady qualifies rs1Data/rs2Data in the same cycle; an op that
  // needs them holds IF/ID until the cycle it is high, then issues once.
  assign needs_ops = is_beq | is_bne | is_callr;
  assign frozen    = (state == HALTED) | is_halt;
  assign wait_ops  = needs_ops & ~operandsReady & ~frozen;
  assign active    = ~frozen & ~wait_ops;

  assign depth_full  = (depth == DW'(STACK_DEPTH));
  assign depth_empty = (depth == '0);
  assign call_go     = active & is_call  & ~depth_full;
  assign callr_go    = active & is_callr & ~depth_full;
  assign ret_go      = active & is_ret   & ~depth_empty;
  assign overflow    = active & (is_call | is_callr) & depth_full;
  assign underflow   = active & is_ret & depth_empty;

  assign SIG_Jump       = active & is_j;
  assign SIG_Call       = call_go;
  assign SIG_CALL_RS1   = callr_go;
  assign SIG_RET        = ret_go;
  assign SIG_BEQ        = active & is_beq;
  assign SIG_BNE        = active & is_bne;
  assign SIG_EQ         = active & operandsReady & (rs1Data == rs2Data);
  assign callRs1Address = rs1Data;
  assign stallOut       = frozen | wait_ops;
  assign halted         = (state == HALTED);
  assign dbg_state      = state;
  assign dbg_depth      = depth;

  branch_target_calc u_target (
    .pc4            (idPC4),
    .imm26          (idInstr[IMM26_W-1:0]),
    .imm14          (idInstr[IMM14_W-1:0]),
    .jump_address   (jumpAddress),
    .branch_address (branchAddress)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      depth    <= '0;
      stackErr <= 1'b0;
      idInstr  <= '0;
      idPC4    <= '0;
    end else begin
      if (!stallOut) begin
        idInstr <= instructionIn;
        idPC4   <= PC4In;
      end
      if (call_go || callr_go) depth <= depth + DW'(1);
      else if (ret_go)         depth <= depth - DW'(1);
      if (overflow || underflow) stackErr <= 1'b1;
      case (state)
        RUN: begin
          if (is_halt)       state <= HALTED;
          else if (wait_ops) state <= STALL;
        end
        STALL:   if (operandsReady) state <= RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_branch_unit.sv
// Bench for decode_branch_unit: directed scenarios plus random instruction
// streams, each cycle compared against an instruction-level reference model.
module tb_decode_branch_unit;
  import isa_pkg::*;

  localparam int SD = 8;
  localparam int C_NOP = 'h00, C_J = 'h20, C_CALL = 'h21, C_RET = 'h22;
  localparam int C_BEQ = 'h23, C_BNE = 'h24, C_CALLR = 'h25, C_HALT = 'h3F;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] instructionIn, PC4In, rs1Data, rs2Data;
  logic        operandsReady;
  logic        SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET, SIG_BEQ, SIG_BNE, SIG_EQ;
  logic [31:0] jumpAddress, branchAddress, callRs1Address, idInstr, idPC4;
  logic        stallOut, stackErr, halted;
  fsm_state_e  dbg_state;
  logic [3:0]  dbg_depth;

  decode_branch_unit #(.STACK_DEPTH(SD), .OPW(6)) dut (
    .clk(clk), .reset(reset), .instructionIn(instructionIn), .PC4In(PC4In),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .operandsReady(operandsReady),
    .SIG_Jump(SIG_Jump), .SIG_Call(SIG_Call), .SIG_CALL_RS1(SIG_CALL_RS1),
    .SIG_RET(SIG_RET), .SIG_BEQ(SIG_BEQ), .SIG_BNE(SIG_BNE), .SIG_EQ(SIG_EQ),
    .jumpAddress(jumpAddress), .branchAddress(branchAddress),
    .callRs1Address(callRs1Address), .stallOut(stallOut), .idInstr(idInstr),
    .idPC4(idPC4), .stackErr(stackErr), .halted(halted),
    .dbg_state(dbg_state), .dbg_depth(dbg_depth)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: architectural view of IF/ID, depth, error and halt
  logic [31:0] m_instr, m_pc4;
  int          m_depth, n_depth;
  logic        m_err, n_err, m_halted, n_halted, m_waiting;
  logic        e_stall, e_wait;
  logic [6:0]  exp_q[$];

  task automatic model_reset();
    m_instr = '0; m_pc4 = '0; m_depth = 0; m_err = 0; m_halted = 0; m_waiting = 0;
    exp_q.delete();
  endtask

  task automatic model_check();
    int          op, off;
    logic [6:0]  sig, exp_sig;
    logic [31:0] jexp, bexp, st;
    op = int'(m_instr[31:26]);
    sig = '0; e_stall = 0; e_wait = 0;
    n_depth = m_depth; n_err = m_err; n_halted = m_halted;
    if (m_halted) e_stall = 1;
    else if (op == C_HALT) begin e_stall = 1; n_halted = 1; end
    else if ((op == C_BEQ || op == C_BNE || op == C_CALLR) && !operandsReady) begin
      e_stall = 1; e_wait = 1;
    end else begin
      sig[0] = operandsReady && (rs1Data == rs2Data);
      case (op)
        C_J:    sig[6] = 1;
        C_CALL, C_CALLR:
          if (m_depth < SD) begin
            if (op == C_CALL) sig[5] = 1; else sig[4] = 1;
            n_depth = m_depth + 1;
          end else n_err = 1;
        C_RET:
          if (m_depth > 0) begin sig[3] = 1; n_depth = m_depth - 1; end
          else n_err = 1;
        C_BEQ:  sig[2] = 1;
        C_BNE:  sig[1] = 1;
        default: ;
      endcase
    end
    exp_q.push_back(sig);
    jexp = (m_pc4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 4;
    off  = int'(m_instr[13:0]);
    if (off >= 8192) off = off - 16384;
    bexp = m_pc4 + 32'(off * 4);
    st   = m_halted ? 32'(HALTED) : (m_waiting ? 32'(STALL) : 32'(RUN));
    exp_sig = exp_q.pop_front();
    check_eq("sig_vec", {25'd0, SIG_Jump, SIG_Call, SIG_CALL_RS1, SIG_RET, SIG_BEQ, SIG_BNE, SIG_EQ},
             {25'd0, exp_sig});
    check_eq("stall", {31'd0, stallOut}, {31'd0, e_stall});
    check_eq("jump_addr", jumpAddress, jexp);
    check_eq("branch_addr", branchAddress, bexp);
    check_eq("callr_addr", callRs1Address, rs1Data);
    check_eq("id_instr", idInstr, m_instr);
    check_eq("id_pc4", idPC4, m_pc4);
    check_eq("stack_err", {31'd0, stackErr}, {31'd0, m_err});
    check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    check_eq("depth", {28'd0, dbg_depth}, 32'(m_depth));
    check_eq("state", 32'(dbg_state), st);
  endtask

  // driver tasks: inputs change on the falling edge, outputs checked 1ns later
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy);
    instructionIn = instr; PC4In = pc4; rs1Data = a; rs2Data = b; operandsReady = rdy;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!e_stall) begin m_instr = instructionIn; m_pc4 = PC4In; end
    m_depth = n_depth; m_err = n_err; m_halted = n_halted; m_waiting = e_wait;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; instructionIn = '0; PC4In = '0; rs1Data = '0; rs2Data = '0; operandsReady = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  function automatic logic [31:0] mk(input int op, input int imm);
    return (32'(op) << 26) | (32'(imm) & 32'h03FF_FFFF);
  endfunction

  initial begin
    logic [31:0] instr;
    int          op;
    do_reset();
    check_eq("rst_id_instr", idInstr, 32'h0);
    check_eq("rst_id_pc4", idPC4, 32'h0);
    check_eq("rst_stall", {31'd0, stallOut}, 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(RUN));

    // J: region target, then the killed slot arrives as 0
    drive(mk(C_J, 'h40), 32'h104, 0, 0, 1); tick();
    drive(32'h0, 32'h108, 0, 0, 1);
    check_eq("j_sig", {31'd0, SIG_Jump}, 32'h1);
    check_eq("j_target", jumpAddress, 32'h100);
    tick();
    drive(32'h0, 32'h10C, 0, 0, 1);
    check_eq("j_killed", idInstr, 32'h0);
    tick();

    // BEQ with negative offset, equal then unequal operands
    drive(mk(C_BEQ, 'h3FFE), 32'h200, 0, 0, 1); tick();
    drive(mk(C_BEQ, 'h3FFE), 32'h200, 5, 5, 1);
    check_eq("beq_eq", {30'd0, SIG_BEQ, SIG_EQ}, 32'h3);
    check_eq("beq_target", branchAddress, 32'h1F8);
    tick();
    drive(32'h0, 32'h204, 5, 6, 1);
    check_eq("beq_ne", {30'd0, SIG_BEQ, SIG_EQ}, 32'h2);
    tick();

    // BNE waits three cycles for operands, then fires once
    drive(mk(C_BNE, 'h10), 32'h300, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 32'h304, 1, 2, 0);
      check_eq("bne_wait", {30'd0, stallOut, SIG_BNE}, 32'h2);
      tick();
    end
    drive(32'h0, 32'h304, 1, 2, 1);
    check_eq("bne_fire", {31'd0, SIG_BNE}, 32'h1);
    tick();
    drive(32'h0, 32'h308, 1, 2, 1);
    check_eq("bne_once", {31'd0, SIG_BNE}, 32'h0);
    tick();

    // return-stack limits
    for (int i = 0; i < SD + 1; i++) begin drive(mk(C_CALL, i), 32'h400, 0, 0, 1); tick(); end
    drive(mk(C_RET, 0), 32'h500, 0, 0, 1);
    check_eq("call9_sup", {31'd0, SIG_Call}, 32'h0);
    tick();
    check_eq("call9_err", {31'd0, stackErr}, 32'h1);
    for (int i = 0; i < SD; i++) begin
      drive(mk(C_RET, 0), 32'h500, 0, 0, 1);
      check_eq("ret_ok", {31'd0, SIG_RET}, 32'h1);
      tick();
    end
    drive(32'h0, 32'h500, 0, 0, 1);
    check_eq("ret9_sup", {31'd0, SIG_RET}, 32'h0);
    tick();

    // random instruction streams
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: op = C_NOP;   1: op = C_J;    2: op = C_CALL; 3: op = C_RET;
        4: op = C_BEQ;   5: op = C_BNE;  6: op = C_CALLR;
        7, 8: op = int'($urandom_range(1, 31));
        default: op = int'($urandom_range('h26, 'h3E));
      endcase
      instr = mk(op, int'($urandom()));
      drive(instr, $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, 3)),
            32'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      tick();
    end

    // HALT freezes everything until reset
    do_reset();
    drive(mk(C_HALT, 0), 32'h600, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(mk(C_J, 1), 32'h604, 3, 3, 1);
      tick();
    end
    check_eq("halt_flags", {30'd0, halted, stallOut}, 32'h3);
    do_reset();
    drive(32'h0, 32'h0, 0, 0, 0);
    check_eq("halt_rst", {30'd0, halted, stallOut}, 32'h0);
    tick();

    // reset in the middle of a CALLR operand wait
    drive(mk(C_CALL, 0), 32'h700, 0, 0, 1); tick();
    drive(mk(C_CALLR, 0), 32'h704, 0, 0, 1); tick();
    drive(32'h0, 32'h708, 9, 0, 0); tick();
    drive(32'h0, 32'h708, 9, 0, 0);
    check_eq("callr_stall", 32'(dbg_state), 32'(STALL));
    do_reset();
    drive(32'h0, 32'h0, 9, 0, 1);
    check_eq("callr_rst", {28'd0, stallOut, SIG_CALL_RS1, dbg_depth[1:0]}, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
